rx_vc_endpoint: RTL and testbench
=================================

# rx_vc_endpoint

Parametrised receive-side endpoint. It buffers flits from the switch in one FIFO per virtual channel and returns credits to the switch. Software reads the buffered flits over the peripheral bus, choosing which VC to read, and gets a threshold interrupt and error/stall counters. It replaces the single shared RX FIFO on the endpoint side of the switch and adds a selectable credit-return mode.

## Interface
Parameters:
- NUM_VCS, 2 — number of virtual channels (1..8); one FIFO each.
- DEPTH, 4 — entries per VC FIFO; power of two, ≥2.
- BASE_ADDR, 32'h1000 — base of the register window.
- CREDIT_ON_POP, 1 — 1: a credit is returned when software pops a flit; 0: a credit is returned when the flit is accepted.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- n_rst  in  1  synchronous active-low reset.
- flit_in  in  $bits(flit_t)  flit from the switch; metadata.vc selects the FIFO.
- flit_valid  in  1  flit_in is valid this cycle.
- flit_accept  out  1  flit consumed this cycle (combinational).
- credit_granted  out  NUM_VCS  one-cycle credit-return pulse per VC.
- irq  out  1  registered level interrupt.
- bus_if  modport  bus_protocol_if.peripheral_vital  addr/wen/ren/wdata in; rdata/error/request_stall out.

## Operation
- Per-VC state: FIFO of flit_t and count[v], width $clog2(DEPTH+1). full[v] = (count==DEPTH), taken from registered state.
- Accepting a flit with v=flit_in.metadata.vc:
  - If flit_valid, v<NUM_VCS and !full[v]: flit_accept=1 and the flit is pushed.
  - If flit_valid and v≥NUM_VCS: flit_accept=1, the flit is dropped, DROP_CNT increments and no credit is returned.
  - If flit_valid and full[v]: flit_accept=0 and STALL_CNT increments.
- Credit return:
  - CREDIT_ON_POP=0: credit_granted[v] pulses in the accept cycle.
  - CREDIT_ON_POP=1: credit_granted[v] pulses in the cycle the payload of VC v is popped.
  - At most one bit is set per cycle in either mode.
- Register map (offsets from BASE_ADDR). Unlisted reads default rdata=32'hBAD1BAD1.
  - 0x00 STATUS (R): bit v = VC v non-empty; bit 16+v = VC v full.
  - 0x04 VC_SEL (RW, reset 0): a write ≥NUM_VCS sets error and leaves VC_SEL unchanged.
  - 0x08 PAYLOAD (R): returns the head payload of VC_SEL and pops it. If that VC is empty: error=1, no pop.
  - 0x0C METADATA (R): returns the head metadata of VC_SEL, zero-extended, without popping. If empty: error=1.
  - 0x10 COUNT (R): count of VC_SEL.
  - 0x14 IRQ_EN (RW, reset 0): NUM_VCS-bit mask.
  - 0x18 IRQ_THRESH (RW, reset 1): a value of 0 disables irq.
  - 0x1C ERRCNT (R, clear-on-read): [15:0] STALL_CNT and [31:16] DROP_CNT, each saturating at 16'hFFFF.
    - If an increment coincides with the read, the register becomes 1.
- Bus errors:
  - Any wen/ren to an unmapped offset, or a write to a read-only register, gives error=1.
  - request_stall is always 0.
- irq is registered each cycle to OR over v of IRQ_EN[v] && IRQ_THRESH!=0 && count[v]≥IRQ_THRESH.

## Timing
- Reset values:
  - FIFOs empty, all counts 0.
  - VC_SEL=0, IRQ_EN=0, IRQ_THRESH=1, ERRCNT=0.
  - irq=0, credit_granted=0, flit_accept=0.
  - rdata=32'hBAD1BAD1, error=0.
- flit_accept, credit_granted, rdata and error are combinational within the cycle.
- Push and pop take effect at the next clk edge. STATUS and COUNT reflect them one cycle later; irq reflects them two cycles later.
- Simultaneous push and pop on the same non-full VC: the count is unchanged and the FIFO order is preserved.
- Push is refused when full[v] is set, even if a pop happens in the same cycle.
- A pop on VC a and a push on VC b≠a can happen in the same cycle. In mode 0 the push's credit takes that cycle; mode 1 returns only the pop's credit, so no conflict arises.
- Read and write pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset asserted mid-operation: the next edge clears all state. In-flight flits are lost, and no credits or irq are emitted while n_rst=0.

## Test plan
- Credit on pop: with CREDIT_ON_POP=1, push VC1 flit payload 0xCAFE0001 → flit_accept=1 with no credit; VC_SEL←1, read 0x08 → rdata 0xCAFE0001 and credit_granted=2'b10 in the same cycle; COUNT reads 0 next.
- Full VC: push 4 flits to VC0 (DEPTH=4), then hold a 5th flit valid 3 cycles → flit_accept=0 for those cycles and ERRCNT=0x00000003; a second read returns 0.
- Bad VC: flit with vc=5 and NUM_VCS=2 → flit_accept=1 with no credit; ERRCNT[31:16]=1 and STATUS=0.
- Interrupt threshold: IRQ_EN=2'b01, IRQ_THRESH=2; push 2 flits to VC0 → irq rises 2 cycles after the second push; one PAYLOAD pop → irq falls 2 cycles later.
- Ordering and wrap: 10 push/pop pairs on VC0 with payloads 0..9 → popped in order 0..9; COUNT ≤1 throughout.
- Bus errors: read 0x08 when empty → error=1 and rdata=0xBAD1BAD1; write VC_SEL=7 → error=1 and VC_SEL stays 0; read at offset 0x40 → error=1.

Source files
------------

// File: rtl/rx_vc_endpoint_if.sv
// Shared flit types and the peripheral bus interface used by rx_vc_endpoint.
package rx_vc_pkg;

    localparam int unsigned VC_W = 3;

    typedef struct packed {
        logic [4:0]      src;
        logic [VC_W-1:0] vc;
    } flit_meta_t;

    typedef struct packed {
        flit_meta_t  metadata;
        logic [31:0] payload;
    } flit_t;

endpackage

interface bus_protocol_if;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  addr, wen, ren, wdata,
        output rdata, error, request_stall
    );

    modport requester (
        output addr, wen, ren, wdata,
        input  rdata, error, request_stall
    );
endinterface

// File: rtl/rx_vc_endpoint.sv
// Receive endpoint: one flit FIFO per virtual channel, credit return to the
// switch, and a bus register window for reading flits, irq and error counters.
module rx_vc_endpoint
    import rx_vc_pkg::*;
#(
    parameter int unsigned NUM_VCS       = 2,
    parameter int unsigned DEPTH         = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h1000,
    parameter bit          CREDIT_ON_POP = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  flit_t              flit_in,
    input  logic               flit_valid,
    output logic               flit_accept,
    output logic [NUM_VCS-1:0] credit_granted,
    output logic               irq,
    bus_protocol_if.peripheral_vital bus_if
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam logic [31:0] BAD_READ = 32'hBAD1BAD1;

    typedef enum logic [2:0] {
        REG_STATUS, REG_VC_SEL, REG_PAYLOAD, REG_METADATA,
        REG_COUNT, REG_IRQ_EN, REG_IRQ_THRESH, REG_ERRCNT
    } reg_t;

    flit_t              mem   [NUM_VCS][DEPTH];
    logic [CW-1:0]      count [NUM_VCS];
    logic [PW-1:0]      wptr  [NUM_VCS];
    logic [PW-1:0]      rptr  [NUM_VCS];
    logic [NUM_VCS-1:0] full, nonempty, push_v, pop_v, over;
    logic [SW-1:0]      vc_sel;
    logic [NUM_VCS-1:0] irq_en;
    logic [31:0]        irq_thresh;
    logic [15:0]        stall_cnt, drop_cnt;

    logic        vc_ok, tgt_full, do_push, do_drop, do_stall, do_pop, irq_d;
    logic        sel_nonempty, vc_sel_we, irq_en_we, thresh_we, errcnt_rd, in_win;
    logic [CW-1:0] sel_count;
    flit_t       head;
    logic [31:0] offset, status;
    reg_t        reg_idx;

    always_comb begin
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            full[v]     = (count[v] == CW'(DEPTH));
            nonempty[v] = (count[v] != '0);
        end
    end

    // Flit acceptance uses registered fullness only, so a same-cycle pop never frees a slot.
    always_comb begin
        vc_ok    = 32'(flit_in.metadata.vc) < NUM_VCS;
        tgt_full = 1'b0;
        for (int unsigned v = 0; v < NUM_VCS; v++)
            if (flit_in.metadata.vc == VC_W'(v)) tgt_full = full[v];
        do_push  = n_rst && flit_valid && vc_ok && !tgt_full;
        do_drop  = n_rst && flit_valid && !vc_ok;
        do_stall = n_rst && flit_valid && vc_ok && tgt_full;
        for (int unsigned v = 0; v < NUM_VCS; v++)
            push_v[v] = do_push && (flit_in.metadata.vc == VC_W'(v));
        flit_accept = do_push || do_drop;
    end

    always_comb begin
        head         = '0;
        sel_count    = '0;
        sel_nonempty = 1'b0;
        status       = '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            status[v]      = nonempty[v];
            status[16 + v] = full[v];
            if (vc_sel == SW'(v)) begin
                head         = mem[v][rptr[v]];
                sel_count    = count[v];
                sel_nonempty = nonempty[v];
            end
        end
    end

    always_comb begin
        offset        = bus_if.addr - BASE_ADDR;
        in_win        = (bus_if.addr >= BASE_ADDR) && (offset < 32'h20) && (offset[1:0] == 2'b00);
        reg_idx       = reg_t'(offset[4:2]);
        bus_if.rdata  = BAD_READ;
        bus_if.error  = 1'b0;
        bus_if.request_stall = 1'b0;
        do_pop    = 1'b0;
        vc_sel_we = 1'b0;
        irq_en_we = 1'b0;
        thresh_we = 1'b0;
        errcnt_rd = 1'b0;
        if (n_rst && bus_if.ren) begin
            if (!in_win) begin
                bus_if.error = 1'b1;
            end else begin
                case (reg_idx)
                    REG_STATUS:     bus_if.rdata = status;
                    REG_VC_SEL:     bus_if.rdata = 32'(vc_sel);
                    REG_PAYLOAD:    if (sel_nonempty) begin
                                        bus_if.rdata = head.payload;
                                        do_pop       = 1'b1;
                                    end else bus_if.error = 1'b1;
                    REG_METADATA:   if (sel_nonempty) bus_if.rdata = 32'(head.metadata);
                                    else bus_if.error = 1'b1;
                    REG_COUNT:      bus_if.rdata = 32'(sel_count);
                    REG_IRQ_EN:     bus_if.rdata = 32'(irq_en);
                    REG_IRQ_THRESH: bus_if.rdata = irq_thresh;
                    REG_ERRCNT:     begin
                                        bus_if.rdata = {drop_cnt, stall_cnt};
                                        errcnt_rd    = 1'b1;
                                    end
                    default:        bus_if.error = 1'b1;
                endcase
            end
        end
        if (n_rst && bus_if.wen) begin
            if (!in_win) begin
                bus_if.error = 1'b1;
            end else begin
                case (reg_idx)
                    REG_VC_SEL:     if (bus_if.wdata < NUM_VCS) vc_sel_we = 1'b1;
                                    else bus_if.error = 1'b1;
                    REG_IRQ_EN:     irq_en_we = 1'b1;
                    REG_IRQ_THRESH: thresh_we = 1'b1;
                    default:        bus_if.error = 1'b1;
                endcase
            end
        end
        for (int unsigned v = 0; v < NUM_VCS; v++)
            pop_v[v] = do_pop && (vc_sel == SW'(v));
        credit_granted = CREDIT_ON_POP ? pop_v : push_v;
    end

    always_comb begin
        for (int unsigned v = 0; v < NUM_VCS; v++)
            over[v] = irq_en[v] && (32'(count[v]) >= irq_thresh);
        irq_d = (irq_thresh != '0) && (|over);
    end

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NUM_VCS; v++)
            if (push_v[v]) mem[v][wptr[v]] <= flit_in;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                count[v] <= '0;
                wptr[v]  <= '0;
                rptr[v]  <= '0;
            end
            vc_sel     <= '0;
            irq_en     <= '0;
            irq_thresh <= 32'd1;
            stall_cnt  <= '0;
            drop_cnt   <= '0;
            irq        <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (push_v[v]) wptr[v] <= wptr[v] + PW'(1);
                if (pop_v[v])  rptr[v] <= rptr[v] + PW'(1);
                count[v] <= count[v] + CW'(push_v[v]) - CW'(pop_v[v]);
            end
            if (vc_sel_we) vc_sel     <= bus_if.wdata[SW-1:0];
            if (irq_en_we) irq_en     <= bus_if.wdata[NUM_VCS-1:0];
            if (thresh_we) irq_thresh <= bus_if.wdata;
            // A read clears the counter, but an event in the read cycle is kept as 1.
            if (errcnt_rd)                         stall_cnt <= do_stall ? 16'd1 : '0;
            else if (do_stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 16'd1;
            if (errcnt_rd)                         drop_cnt  <= do_drop ? 16'd1 : '0;
            else if (do_drop && drop_cnt != '1)    drop_cnt  <= drop_cnt + 16'd1;
            irq <= irq_d;
        end
    end

endmodule

// File: tb/tb_rx_vc_endpoint.sv
// Bench for rx_vc_endpoint: directed scenarios plus random traffic against a
// queue-based model; a second instance covers the credit-on-accept mode.
module tb_rx_vc_endpoint;
    import rx_vc_pkg::*;

    localparam int NV = 2;
    localparam int DP = 4;
    localparam logic [31:0] BASE = 32'h1000;
    localparam logic [31:0] BAD  = 32'hBAD1BAD1;

    logic clk = 1'b0;
    logic n_rst;
    flit_t fin;
    logic fvalid;
    logic acc1, acc0, irq1, irq0;
    logic [NV-1:0] cred1, cred0;

    bus_protocol_if bif ();
    bus_protocol_if bif0 ();

    rx_vc_endpoint #(.NUM_VCS(NV), .DEPTH(DP), .BASE_ADDR(BASE), .CREDIT_ON_POP(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .flit_in(fin), .flit_valid(fvalid),
        .flit_accept(acc1), .credit_granted(cred1), .irq(irq1), .bus_if(bif)
    );

    rx_vc_endpoint #(.NUM_VCS(NV), .DEPTH(DP), .BASE_ADDR(BASE), .CREDIT_ON_POP(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .flit_in(fin), .flit_valid(fvalid),
        .flit_accept(acc0), .credit_granted(cred0), .irq(irq0), .bus_if(bif0)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    flit_t mq [NV][$];
    int    cnt0 [NV];
    int    stall_m = 0, drop_m = 0, vcsel_m = 0;
    logic [NV-1:0] irqen_m = '0;
    logic [31:0]   thr_m = 32'd1;
    logic          irq_m = 1'b0;

    // Expectations for the current cycle and pending model updates
    logic exp_acc, exp_acc0, exp_err;
    logic [NV-1:0] exp_cred, exp_cred0;
    logic [31:0] exp_rdata, p_wdata;
    flit_t p_flit;
    int p_vc;
    bit p_push, p_push0, p_pop, p_stall, p_drop, p_clr, p_wsel, p_wien, p_wthr;

    task automatic setup(input logic v, input int vc, input logic [31:0] pay,
                         input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        bit mapped;
        int idx;
        fvalid = v;
        fin.metadata.vc  = 3'(vc);
        fin.metadata.src = 5'($urandom);
        fin.payload = pay;
        bif.ren = ren; bif.wen = wen; bif.addr = addr; bif.wdata = wdata;
        p_flit = fin; p_vc = vc; p_wdata = wdata;
        {p_push, p_push0, p_pop, p_stall, p_drop, p_clr, p_wsel, p_wien, p_wthr} = '0;
        exp_acc = 0; exp_acc0 = 0; exp_cred = '0; exp_cred0 = '0;
        exp_rdata = BAD; exp_err = 0;
        if (v) begin
            if (vc >= NV) begin
                exp_acc = 1; exp_acc0 = 1; p_drop = 1;
            end else begin
                if (mq[vc].size() < DP) begin exp_acc = 1; p_push = 1; end
                else p_stall = 1;
                if (cnt0[vc] < DP) begin exp_acc0 = 1; p_push0 = 1; exp_cred0[vc] = 1'b1; end
            end
        end
        off = addr - BASE;
        mapped = (addr >= BASE) && (off < 32) && (off[1:0] == 2'b00);
        idx = int'(off[4:2]);
        if (ren) begin
            if (!mapped) exp_err = 1;
            else case (idx)
                0: begin
                    exp_rdata = '0;
                    for (int i = 0; i < NV; i++) begin
                        if (mq[i].size() > 0)  exp_rdata[i] = 1'b1;
                        if (mq[i].size() == DP) exp_rdata[16+i] = 1'b1;
                    end
                end
                1: exp_rdata = 32'(vcsel_m);
                2: if (mq[vcsel_m].size() > 0) begin
                       exp_rdata = mq[vcsel_m][0].payload; p_pop = 1; exp_cred[vcsel_m] = 1'b1;
                   end else exp_err = 1;
                3: if (mq[vcsel_m].size() > 0) exp_rdata = 32'(mq[vcsel_m][0].metadata);
                   else exp_err = 1;
                4: exp_rdata = 32'(mq[vcsel_m].size());
                5: exp_rdata = 32'(irqen_m);
                6: exp_rdata = thr_m;
                default: begin exp_rdata = {16'(drop_m), 16'(stall_m)}; p_clr = 1; end
            endcase
        end
        if (wen) begin
            if (!mapped) exp_err = 1;
            else if (idx == 1) begin if (wdata < NV) p_wsel = 1; else exp_err = 1; end
            else if (idx == 5) p_wien = 1;
            else if (idx == 6) p_wthr = 1;
            else exp_err = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!n_rst) begin
            for (int i = 0; i < NV; i++) begin mq[i].delete(); cnt0[i] = 0; end
            stall_m = 0; drop_m = 0; vcsel_m = 0; irqen_m = '0; thr_m = 32'd1; irq_m = 0;
        end else begin
            irq_m = 0;
            for (int i = 0; i < NV; i++)
                if (irqen_m[i] && thr_m != 0 && mq[i].size() >= thr_m) irq_m = 1;
            if (p_push) mq[p_vc].push_back(p_flit);
            if (p_pop) void'(mq[vcsel_m].pop_front());
            if (p_push0) cnt0[p_vc]++;
            if (p_clr) stall_m = p_stall ? 1 : 0;
            else if (p_stall && stall_m < 65535) stall_m++;
            if (p_clr) drop_m = p_drop ? 1 : 0;
            else if (p_drop && drop_m < 65535) drop_m++;
            if (p_wsel) vcsel_m = int'(p_wdata);
            if (p_wien) irqen_m = p_wdata[NV-1:0];
            if (p_wthr) thr_m = p_wdata;
        end
        #1;
        setup(0, 0, 0, 0, 0, BASE, 0);
    endtask

    task automatic test_reset();
        n_rst = 0;
        setup(1, 0, 32'h1234, 1, 0, BASE + 8, 0);
        #1;
        n_vec++; if (acc1 !== 1'b0) begin n_err++; $display("FAIL rst_accept: got %b want 0", acc1); end
        n_vec++; if (cred1 !== 2'b00 || cred0 !== 2'b00) begin n_err++; $display("FAIL rst_credit: got %b/%b want 00", cred1, cred0); end
        n_vec++; if (bif.rdata !== BAD || bif.error !== 1'b0) begin n_err++; $display("FAIL rst_bus: got %h/%b want %h/0", bif.rdata, bif.error, BAD); end
        tick(); tick();
        n_vec++; if (irq1 !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq1); end
        n_rst = 1;
        setup(0, 0, 0, 1, 0, BASE + 0, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL rst_status: got %h want 0", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 4, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL rst_vcsel: got %h want 0", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h18, 0); #1;
        n_vec++; if (bif.rdata !== 32'h1) begin n_err++; $display("FAIL rst_thresh: got %h want 1", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h1C, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL rst_errcnt: got %h want 0", bif.rdata); end
        tick();
    endtask

    task automatic test_credit_on_pop();
        setup(1, 1, 32'hCAFE0001, 0, 0, BASE, 0); #1;
        n_vec++; if (acc1 !== 1'b1 || cred1 !== 2'b00) begin n_err++; $display("FAIL cop_push: got acc %b cred %b want 1 00", acc1, cred1); end
        n_vec++; if (acc0 !== 1'b1 || cred0 !== 2'b10) begin n_err++; $display("FAIL coa_push: got acc %b cred %b want 1 10", acc0, cred0); end
        tick();
        setup(0, 0, 0, 0, 1, BASE + 4, 1); #1;
        n_vec++; if (bif.error !== 1'b0) begin n_err++; $display("FAIL cop_sel: got err %b want 0", bif.error); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 8, 0); #1;
        n_vec++; if (bif.rdata !== 32'hCAFE0001 || cred1 !== 2'b10) begin n_err++; $display("FAIL cop_pop: got %h cred %b want cafe0001 10", bif.rdata, cred1); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h10, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL cop_count: got %h want 0", bif.rdata); end
        tick();
        setup(0, 0, 0, 0, 1, BASE + 4, 0); tick();
    endtask

    task automatic test_full_vc();
        for (int i = 0; i < 4; i++) begin
            setup(1, 0, 32'hF000 + i, 0, 0, BASE, 0); #1;
            n_vec++; if (acc1 !== 1'b1) begin n_err++; $display("FAIL full_push%0d: got %b want 1", i, acc1); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            setup(1, 0, 32'hF004, 0, 0, BASE, 0); #1;
            n_vec++; if (acc1 !== 1'b0) begin n_err++; $display("FAIL full_stall%0d: got %b want 0", i, acc1); end
            tick();
        end
        setup(0, 0, 0, 1, 0, BASE + 32'h1C, 0); #1;
        n_vec++; if (bif.rdata !== 32'h3) begin n_err++; $display("FAIL full_errcnt: got %h want 3", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h1C, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL full_errclr: got %h want 0", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE, 0); #1;
        n_vec++; if (bif.rdata !== 32'h00010001) begin n_err++; $display("FAIL full_status: got %h want 00010001", bif.rdata); end
        tick();
        for (int i = 0; i < 4; i++) begin
            setup(0, 0, 0, 1, 0, BASE + 8, 0); #1;
            n_vec++; if (bif.rdata !== 32'hF000 + i) begin n_err++; $display("FAIL full_drain%0d: got %h want %h", i, bif.rdata, 32'hF000 + i); end
            tick();
        end
    endtask

    task automatic test_bad_vc();
        setup(1, 5, 32'hDEAD, 0, 0, BASE, 0); #1;
        n_vec++; if (acc1 !== 1'b1 || cred1 !== 2'b00) begin n_err++; $display("FAIL bad_accept: got %b cred %b want 1 00", acc1, cred1); end
        n_vec++; if (acc0 !== 1'b1 || cred0 !== 2'b00) begin n_err++; $display("FAIL bad_accept0: got %b cred %b want 1 00", acc0, cred0); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h1C, 0); #1;
        n_vec++; if (bif.rdata !== 32'h00010000) begin n_err++; $display("FAIL bad_errcnt: got %h want 00010000", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL bad_status: got %h want 0", bif.rdata); end
        tick();
    endtask

    task automatic test_irq_threshold();
        setup(0, 0, 0, 0, 1, BASE + 32'h14, 1); tick();
        setup(0, 0, 0, 0, 1, BASE + 32'h18, 2); tick();
        setup(1, 0, 32'h11, 0, 0, BASE, 0); tick();
        setup(1, 0, 32'h22, 0, 0, BASE, 0); tick();
        n_vec++; if (irq1 !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq1); end
        tick();
        n_vec++; if (irq1 !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", irq1); end
        setup(0, 0, 0, 1, 0, BASE + 8, 0); tick();
        n_vec++; if (irq1 !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b want 1", irq1); end
        tick();
        n_vec++; if (irq1 !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b want 0", irq1); end
        setup(0, 0, 0, 1, 0, BASE + 8, 0); tick();
        setup(0, 0, 0, 0, 1, BASE + 32'h14, 0); tick();
    endtask

    task automatic test_order_wrap();
        setup(1, 0, 0, 0, 0, BASE, 0); tick();
        for (int i = 1; i < 10; i++) begin
            setup(1, 0, i, 1, 0, BASE + 8, 0); #1;
            n_vec++; if (bif.rdata !== 32'(i - 1) || acc1 !== 1'b1 || cred1 !== 2'b01) begin
                n_err++; $display("FAIL wrap_pop%0d: got %h acc %b cred %b want %h 1 01", i, bif.rdata, acc1, cred1, i - 1);
            end
            tick();
            setup(0, 0, 0, 1, 0, BASE + 32'h10, 0); #1;
            n_vec++; if (bif.rdata !== 32'h1) begin n_err++; $display("FAIL wrap_count%0d: got %h want 1", i, bif.rdata); end
            tick();
        end
        setup(0, 0, 0, 1, 0, BASE + 8, 0); #1;
        n_vec++; if (bif.rdata !== 32'h9) begin n_err++; $display("FAIL wrap_last: got %h want 9", bif.rdata); end
        tick();
    endtask

    task automatic test_bus_errors();
        setup(0, 0, 0, 1, 0, BASE + 8, 0); #1;
        n_vec++; if (bif.error !== 1'b1 || bif.rdata !== BAD || cred1 !== 2'b00) begin n_err++; $display("FAIL err_empty: got %b %h %b want 1 %h 00", bif.error, bif.rdata, cred1, BAD); end
        tick();
        setup(0, 0, 0, 0, 1, BASE + 4, 7); #1;
        n_vec++; if (bif.error !== 1'b1) begin n_err++; $display("FAIL err_vcsel: got %b want 1", bif.error); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 4, 0); #1;
        n_vec++; if (bif.rdata !== 32'h0) begin n_err++; $display("FAIL err_vcsel_keep: got %h want 0", bif.rdata); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h40, 0); #1;
        n_vec++; if (bif.error !== 1'b1 || bif.rdata !== BAD) begin n_err++; $display("FAIL err_unmapped: got %b %h want 1 %h", bif.error, bif.rdata, BAD); end
        tick();
        setup(0, 0, 0, 0, 1, BASE, 32'hFFFF); #1;
        n_vec++; if (bif.error !== 1'b1) begin n_err++; $display("FAIL err_ro_write: got %b want 1", bif.error); end
        tick();
        setup(0, 0, 0, 1, 0, BASE + 32'h0C, 0); #1;
        n_vec++; if (bif.error !== 1'b1) begin n_err++; $display("FAIL err_meta_empty: got %b want 1", bif.error); end
        tick();
    endtask

    task automatic test_random();
        n_rst = 0; tick(); n_rst = 1;
        setup(0, 0, 0, 0, 1, BASE + 32'h14, 3); tick();
        setup(0, 0, 0, 0, 1, BASE + 32'h18, $urandom_range(0, 3)); tick();
        for (int c = 0; c < 400; c++) begin
            int r, vcv;
            logic fv, rn, wn;
            logic [31:0] ad, wd;
            fv = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 19);
            vcv = (r < 9) ? 0 : (r < 18) ? 1 : (r == 18) ? 2 : 5;
            rn = 0; wn = 0; ad = BASE; wd = $urandom;
            r = $urandom_range(0, 19);
            if (r < 7)       begin rn = 1; ad = BASE + 8; end
            else if (r < 10) begin rn = 1; ad = BASE + 4 * $urandom_range(0, 7); end
            else if (r < 12) begin wn = 1; ad = BASE + 4; wd = $urandom_range(0, 2); end
            else if (r == 12) begin rn = 1; ad = BASE + 32'h40; end
            else if (r == 13) begin wn = 1; ad = BASE + 32'h18; wd = $urandom_range(0, 4); end
            setup(fv, vcv, $urandom, rn, wn, ad, wd); #1;
            n_vec++; if (acc1 !== exp_acc || cred1 !== exp_cred) begin n_err++; $display("FAIL rnd_flow c%0d: got acc %b cred %b want %b %b", c, acc1, cred1, exp_acc, exp_cred); end
            n_vec++; if (acc0 !== exp_acc0 || cred0 !== exp_cred0) begin n_err++; $display("FAIL rnd_flow0 c%0d: got acc %b cred %b want %b %b", c, acc0, cred0, exp_acc0, exp_cred0); end
            n_vec++; if (bif.rdata !== exp_rdata || bif.error !== exp_err) begin n_err++; $display("FAIL rnd_bus c%0d: got %h err %b want %h %b", c, bif.rdata, bif.error, exp_rdata, exp_err); end
            n_vec++; if (irq1 !== irq_m || bif.request_stall !== 1'b0) begin n_err++; $display("FAIL rnd_irq c%0d: got %b stall %b want %b 0", c, irq1, bif.request_stall, irq_m); end
            tick();
        end
        n_vec++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL rnd_irq0: got %b want 0", irq0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif0.addr = '0; bif0.wen = 1'b0; bif0.ren = 1'b0; bif0.wdata = '0;
        for (int i = 0; i < NV; i++) cnt0[i] = 0;
        n_rst = 0;
        setup(0, 0, 0, 0, 0, BASE, 0);
        test_reset();
        test_credit_on_pop();
        test_full_vc();
        test_bad_vc();
        test_irq_threshold();
        test_order_wrap();
        test_bus_errors();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
